pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Parametrised program-counter unit for the fetch stage. It replaces the free-running +4 counter with:
- a valid/ready fetch handshake
- stall and halt control
- prioritised redirects (trap > branch/jump) with alignment checking
- a configurable reset vector

It sits between the control unit (redirect and trap sources) and instruction memory.

Parameters:
- XLEN, 32, PC width in bits
- INC, 4, byte increment per sequential fetch; power of two, at least 1
- RESET_VEC, 32'h0000_0000, PC value loaded on reset
- TRAP_VEC, 32'h0000_0100, PC value loaded on trap
- RAS_DEPTH, 4, return-address stack entries; power of two; used only with PC_RAS_EN

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall_i  in  1  hold PC; suppresses fetch_valid_o
- halt_i  in  1  request entry to HALT
- resume_i  in  1  leave HALT
- redirect_valid_i  in  1  branch/jump taken this cycle
- redirect_target_i  in  XLEN  branch/jump target
- trap_i  in  1  exception/interrupt redirect to TRAP_VEC
- fetch_valid_o  out  1  pc_o is a valid fetch request
- fetch_ready_i  in  1  memory accepts the request
- pc_o  out  XLEN  current fetch PC
- misaligned_o  out  1  one-cycle pulse: redirect target not INC-aligned
- halted_o  out  1  FSM is in HALT
- call_i  in  1  push return address (PC_RAS_EN only)
- ret_i  in  1  pop and redirect (PC_RAS_EN only)
- ras_empty_o  out  1  stack empty (PC_RAS_EN only)

Behaviour:
- Reset (asynchronous, any time, including mid-handshake or in HALT):
  - pc_o = RESET_VEC
  - FSM = BOOT
  - fetch_valid_o = 0, misaligned_o = 0, halted_o = 0
  - RAS cleared
- FSM states:
  - BOOT: exactly one cycle after reset deasserts, fetch_valid_o = 0, then -> RUN.
  - RUN: fetch_valid_o = !stall_i. halt_i -> HALT at the next edge; the current handshake, if it fires, still advances the PC.
  - HALT: fetch_valid_o = 0, halted_o = 1, pc_o frozen. resume_i -> RUN. trap_i in HALT loads TRAP_VEC and goes -> RUN.
- PC next-value priority, evaluated every cycle in RUN:
  1. trap_i -> TRAP_VEC
  2. redirect_valid_i -> aligned target
  3. ret_i (PC_RAS_EN only) -> stack top
  4. fetch_valid_o && fetch_ready_i -> pc_o + INC
  5. otherwise hold.
- Redirects:
  - Take effect at the next edge regardless of fetch_ready_i or stall_i.
  - A pending unaccepted request is abandoned; fetch_valid_o may stay high with the new pc_o. Memory treats pc_o as combinationally sampled.
- Alignment: the low log2(INC) bits of redirect_target_i are forced to 0. misaligned_o = 1 for exactly the cycle after a misaligned redirect is taken.
- Arithmetic is modulo 2^XLEN; all-ones region + INC wraps to 0 with no flag.
- Simultaneous inputs:
  - trap_i with redirect_valid_i: the trap wins and misaligned_o is not raised.
  - stall_i with a redirect: the redirect is applied.
  - halt_i with trap_i in RUN: the trap is applied and the state goes to HALT.
- Latency: input to pc_o update is one cycle; there is no combinational path from inputs to pc_o.

Optional Feature:
- Macro: PC_RAS_EN.
- With the macro defined:
  - A RAS_DEPTH-entry circular return-address stack is present.
  - call_i pushes pc_o + INC. It applies only in the cycle its handshake fires, and is ignored if a trap or redirect wins that cycle.
  - ret_i pops and redirects at priority 3.
  - Overflow overwrites the oldest entry.
  - ret_i when empty redirects to RESET_VEC and pulses misaligned_o.
  - call_i and ret_i in the same cycle: return to the top entry, then replace it with the new return address (the stack count is unchanged).
- Without the macro:
  - call_i and ret_i are ignored.
  - ras_empty_o is tied to 1.
  - No storage is inferred.

Decomposition:
- Shared package pc_pkg holds:
  - the FSM state enum (BOOT, RUN, HALT)
  - default XLEN
  - the INC alignment-mask helper function
  - the redirect-source enum (NONE, TRAP, BRANCH, RET, SEQ)
- One sub-module, pc_ras: the stack (push, pop, full, empty, circular pointer), instantiated only under PC_RAS_EN.

Test Plan:
1. Reset, then fetch_ready_i = 1 for 4 cycles -> BOOT cycle with fetch_valid_o = 0, then pc_o = 0, 4, 8, 12.
2. fetch_ready_i = 0 for 3 cycles, then redirect_valid_i with target 0x1002 -> pc_o holds, then becomes 0x1000; misaligned_o = 1 for one cycle.
3. trap_i and redirect_valid_i (target 0x2000) in the same cycle -> pc_o = 0x100, misaligned_o = 0.
4. halt_i at pc_o = 0x20, then resume_i after 5 cycles -> halted_o = 1 and fetch_valid_o = 0 throughout; resumes at 0x20. Reset asserted mid-HALT -> pc_o = 0 immediately.
5. pc_o = 0xFFFF_FFFC with handshake -> pc_o = 0x0000_0000.
6. (PC_RAS_EN) call at 0x40, call at 0x80, ret, ret, ret -> pc_o = 0x84, then 0x44, then 0x0 with misaligned_o pulse. Five calls with RAS_DEPTH = 4 -> oldest entry lost.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage PC unit.
// The PC_RAS_EN macro enables the return-address stack.
package pc_pkg;

   localparam int PC_XLEN = 32;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_TRAP,
      SRC_BRANCH,
      SRC_RET,
      SRC_SEQ
   } src_e;

   // Mask that clears the low log2(inc) bits; inc is a power of two.
   function automatic logic [63:0] align_mask(input int unsigned inc);
      return ~(64'(inc) - 64'd1);
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; overflow overwrites the oldest entry.
// Only instantiated when PC_RAS_EN is defined.
module pc_ras
   import pc_pkg::*;
#(
   parameter int XLEN  = PC_XLEN,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [XLEN-1:0] data_i,
   output logic [XLEN-1:0] top_o,
   output logic            empty_o,
   output logic            full_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [PW-1:0]   sp_q;
   logic [PW-1:0]   top_idx;
   logic [CW-1:0]   cnt_q;

   assign top_idx = sp_q - 1'b1;
   assign top_o   = mem_q[top_idx];
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_i && pop_i && !empty_o) begin
         // return-and-call: top is replaced, depth unchanged
         mem_q[top_idx] <= data_i;
      end else if (push_i) begin
         mem_q[sp_q] <= data_i;
         sp_q        <= sp_q + 1'b1;
         if (!full_o) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else if (pop_i && !empty_o) begin
         sp_q  <= top_idx;
         cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC unit: handshake, stall/halt FSM, prioritised redirects.
// Define PC_RAS_EN to add the return-address stack (call_i/ret_i).
module pc_fetch_ctrl
   import pc_pkg::*;
#(
   parameter int              XLEN      = PC_XLEN,
   parameter int              INC       = 4,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
   parameter int              RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_i,
   input  logic            halt_i,
   input  logic            resume_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_target_i,
   input  logic            trap_i,
   output logic            fetch_valid_o,
   input  logic            fetch_ready_i,
   output logic [XLEN-1:0] pc_o,
   output logic            misaligned_o,
   output logic            halted_o,
   input  logic            call_i,
   input  logic            ret_i,
   output logic            ras_empty_o
);

   localparam logic [XLEN-1:0] MASK  = XLEN'(align_mask(INC));
   localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

   state_e          state_q, state_d;
   src_e            src;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            mis_q, mis_d;
   logic            fire;
   logic            ret_act;
   logic [XLEN-1:0] ras_top;
   logic            ras_empty;
   logic [XLEN-1:0] seq_pc;

   assign fire   = fetch_valid_o & fetch_ready_i;
   assign seq_pc = pc_q + INC_W;

`ifdef PC_RAS_EN
   logic ras_push;
   logic ras_full_unused;

   assign ret_act  = ret_i;
   assign ras_push = call_i & fire &
                     ((src == SRC_SEQ) | (src == SRC_RET));

   pc_ras #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .reset   (reset),
      .push_i  (ras_push),
      .pop_i   (src == SRC_RET),
      .data_i  (seq_pc),
      .top_o   (ras_top),
      .empty_o (ras_empty),
      .full_o  (ras_full_unused)
   );
`else
   logic unused_ras;

   assign unused_ras = call_i | ret_i;
   assign ret_act    = 1'b0;
   assign ras_top    = '0;
   assign ras_empty  = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_VEC;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         mis_q   <= mis_d;
      end
   end

   always_comb begin
      src = SRC_NONE;
      if (state_q == ST_RUN) begin
         if (trap_i) begin
            src = SRC_TRAP;
         end else if (redirect_valid_i) begin
            src = SRC_BRANCH;
         end else if (ret_act) begin
            src = SRC_RET;
         end else if (fire) begin
            src = SRC_SEQ;
         end
      end else if (state_q == ST_HALT && trap_i) begin
         src = SRC_TRAP;
      end
   end

   always_comb begin
      pc_d  = pc_q;
      mis_d = 1'b0;
      unique case (src)
         SRC_TRAP: pc_d = TRAP_VEC;
         SRC_BRANCH: begin
            pc_d  = redirect_target_i & MASK;
            mis_d = |(redirect_target_i & ~MASK);
         end
         SRC_RET: begin
            pc_d  = ras_empty ? RESET_VEC : ras_top;
            mis_d = ras_empty;
         end
         SRC_SEQ: pc_d = seq_pc;
         default: pc_d = pc_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN:  if (halt_i) state_d = ST_HALT;
         ST_HALT: if (resume_i || trap_i) state_d = ST_RUN;
         default: state_d = ST_BOOT;
      endcase
   end

   always_comb begin
      fetch_valid_o = (state_q == ST_RUN) & ~stall_i;
      halted_o      = (state_q == ST_HALT);
      pc_o          = pc_q;
      misaligned_o  = mis_q;
      ras_empty_o   = ras_empty;
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: vector table plus
// hand sequences for halt, reset and (with PC_RAS_EN) the stack.
module tb_pc_fetch_ctrl;

   typedef struct {
      logic        stall, halt, resume, redir;
      logic [31:0] tgt;
      logic        trap, ready, call, ret;
      logic [31:0] e_pc;
      logic        e_valid, e_mis, e_halt, e_empty;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic        valid, mis, halt, empty;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i, halt_i, resume_i;
   logic        redirect_valid_i, trap_i;
   logic [31:0] redirect_target_i;
   logic        fetch_valid_o, fetch_ready_i;
   logic [31:0] pc_o;
   logic        misaligned_o, halted_o;
   logic        call_i, ret_i, ras_empty_o;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q [$];
   vec_t tab   [$];

   always #5 clk = ~clk;

   pc_fetch_ctrl dut (
      .clk               (clk),
      .reset             (reset),
      .stall_i           (stall_i),
      .halt_i            (halt_i),
      .resume_i          (resume_i),
      .redirect_valid_i  (redirect_valid_i),
      .redirect_target_i (redirect_target_i),
      .trap_i            (trap_i),
      .fetch_valid_o     (fetch_valid_o),
      .fetch_ready_i     (fetch_ready_i),
      .pc_o              (pc_o),
      .misaligned_o      (misaligned_o),
      .halted_o          (halted_o),
      .call_i            (call_i),
      .ret_i             (ret_i),
      .ras_empty_o       (ras_empty_o)
   );

   function automatic vec_t v(
      input logic s, h, r, rd,
      input logic [31:0] tg,
      input logic tr, rdy, cl, rt,
      input logic [31:0] ep,
      input logic ev, em, eh, ee);
      vec_t t;
      t.stall = s;   t.halt = h;
      t.resume = r;  t.redir = rd;
      t.tgt = tg;    t.trap = tr;
      t.ready = rdy; t.call = cl;
      t.ret = rt;    t.e_pc = ep;
      t.e_valid = ev; t.e_mis = em;
      t.e_halt = eh;  t.e_empty = ee;
      return t;
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic run(input vec_t t);
      exp_t e;
      stall_i           = t.stall;
      halt_i            = t.halt;
      resume_i          = t.resume;
      redirect_valid_i  = t.redir;
      redirect_target_i = t.tgt;
      trap_i            = t.trap;
      fetch_ready_i     = t.ready;
      call_i            = t.call;
      ret_i             = t.ret;
      e.pc    = t.e_pc;
      e.valid = t.e_valid;
      e.mis   = t.e_mis;
      e.halt  = t.e_halt;
      e.empty = t.e_empty;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("pc", pc_o, e.pc);
      chk("valid", 32'(fetch_valid_o), 32'(e.valid));
      chk("misaligned", 32'(misaligned_o), 32'(e.mis));
      chk("halted", 32'(halted_o), 32'(e.halt));
      chk("ras_empty", 32'(ras_empty_o), 32'(e.empty));
   endtask

   task automatic idle_chk(input string nm, input logic [31:0] epc);
      chk({nm, "_pc"}, pc_o, epc);
      chk({nm, "_valid"}, 32'(fetch_valid_o), 32'd0);
      chk({nm, "_mis"}, 32'(misaligned_o), 32'd0);
      chk({nm, "_halted"}, 32'(halted_o), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      stall_i = 0; halt_i = 0; resume_i = 0;
      redirect_valid_i = 0; redirect_target_i = '0;
      trap_i = 0; fetch_ready_i = 0;
      call_i = 0; ret_i = 0;

      // sequential fetch, redirects, stall and wrap-around
      //           s h r rd tgt            tr rdy c rt pc            v m h e
      tab.push_back(v(0,0,0,0,32'h0,        0,1,0,0, 32'h0,        1,0,0,1));
      tab.push_back(v(0,0,0,0,32'h0,        0,1,0,0, 32'h4,        1,0,0,1));
      tab.push_back(v(0,0,0,0,32'h0,        0,1,0,0, 32'h8,        1,0,0,1));
      tab.push_back(v(0,0,0,0,32'h0,        0,1,0,0, 32'hC,        1,0,0,1));
      tab.push_back(v(0,0,0,0,32'h0,        0,0,0,0, 32'hC,        1,0,0,1));
      tab.push_back(v(0,0,0,0,32'h0,        0,0,0,0, 32'hC,        1,0,0,1));
      tab.push_back(v(0,0,0,0,32'h0,        0,0,0,0, 32'hC,        1,0,0,1));
      tab.push_back(v(0,0,0,1,32'h1002,     0,0,0,0, 32'h1000,     1,1,0,1));
      tab.push_back(v(0,0,0,0,32'h0,        0,0,0,0, 32'h1000,     1,0,0,1));
      tab.push_back(v(0,0,0,1,32'h2000,     1,0,0,0, 32'h100,      1,0,0,1));
      tab.push_back(v(0,0,0,1,32'h2002,     1,1,0,0, 32'h100,      1,0,0,1));
      tab.push_back(v(1,0,0,1,32'h200,      0,1,0,0, 32'h200,      0,0,0,1));
      tab.push_back(v(1,0,0,0,32'h0,        0,1,0,0, 32'h200,      0,0,0,1));
      tab.push_back(v(0,0,0,0,32'h0,        0,1,0,0, 32'h204,      1,0,0,1));
      tab.push_back(v(0,0,0,1,32'hFFFFFFF8, 0,0,0,0, 32'hFFFFFFF8, 1,0,0,1));
      tab.push_back(v(0,0,0,0,32'h0,        0,1,0,0, 32'hFFFFFFFC, 1,0,0,1));
      tab.push_back(v(0,0,0,0,32'h0,        0,1,0,0, 32'h0,        1,0,0,1));
      tab.push_back(v(0,0,0,0,32'h0,        0,1,0,0, 32'h4,        1,0,0,1));

      #1;
      idle_chk("reset", 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      idle_chk("boot", 32'h0);

      for (int i = 0; i < tab.size(); i++) begin
         run(tab[i]);
      end

      // halt at 0x20, redirect ignored while halted, resume
      run(v(0,0,0,1,32'h18, 0,0,0,0, 32'h18, 1,0,0,1));
      run(v(0,0,0,0,32'h0,  0,1,0,0, 32'h1C, 1,0,0,1));
      run(v(0,0,0,0,32'h0,  0,1,0,0, 32'h20, 1,0,0,1));
      run(v(0,1,0,0,32'h0,  0,0,0,0, 32'h20, 0,0,1,1));
      for (int i = 0; i < 5; i++) begin
         run(v(0,0,0,(i == 2),32'h500, 0,1,0,0, 32'h20, 0,0,1,1));
      end
      run(v(0,0,1,0,32'h0,  0,0,0,0, 32'h20, 1,0,0,1));
      run(v(0,0,0,0,32'h0,  0,1,0,0, 32'h24, 1,0,0,1));
      // halt with a firing handshake still advances
      run(v(0,1,0,0,32'h0,  0,1,0,0, 32'h28, 0,0,1,1));
      // trap leaves HALT
      run(v(0,0,0,0,32'h0,  1,0,0,0, 32'h100,1,0,0,1));
      run(v(0,0,0,0,32'h0,  0,1,0,0, 32'h104,1,0,0,1));
      // halt plus trap in RUN: trap applied, enter HALT
      run(v(0,1,0,0,32'h0,  1,1,0,0, 32'h100,0,0,1,1));
      run(v(0,0,0,0,32'h0,  0,1,0,0, 32'h100,0,0,1,1));

      // asynchronous reset mid-HALT
      #2;
      reset = 1'b1;
      #1;
      idle_chk("async_reset", 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      idle_chk("reboot", 32'h0);
      run(v(0,0,0,0,32'h0, 0,1,0,0, 32'h0, 1,0,0,1));
      run(v(0,0,0,0,32'h0, 0,1,0,0, 32'h4, 1,0,0,1));

`ifdef PC_RAS_EN
      run(v(0,0,0,1,32'h40, 0,0,0,0, 32'h40, 1,0,0,1));
      run(v(0,0,0,0,32'h0,  0,1,1,0, 32'h44, 1,0,0,0));
      run(v(0,0,0,1,32'h80, 0,0,0,0, 32'h80, 1,0,0,0));
      run(v(0,0,0,0,32'h0,  0,1,1,0, 32'h84, 1,0,0,0));
      run(v(0,0,0,0,32'h0,  0,0,0,1, 32'h84, 1,0,0,0));
      run(v(0,0,0,0,32'h0,  0,0,0,1, 32'h44, 1,0,0,1));
      run(v(0,0,0,0,32'h0,  0,0,0,1, 32'h0,  1,1,0,1));
      run(v(0,0,0,0,32'h0,  0,0,0,0, 32'h0,  1,0,0,1));
      // five calls into a four-entry stack
      run(v(0,0,0,1,32'h1000, 0,0,0,0, 32'h1000, 1,0,0,1));
      for (int i = 1; i <= 5; i++) begin
         run(v(0,0,0,0,32'h0, 0,1,1,0,
               32'h1000 + 32'(4 * i), 1,0,0,0));
      end
      for (int i = 5; i >= 2; i--) begin
         run(v(0,0,0,0,32'h0, 0,0,0,1,
               32'h1000 + 32'(4 * i), 1,0,0,(i == 2)));
      end
      run(v(0,0,0,0,32'h0, 0,0,0,1, 32'h0, 1,1,0,1));
`else
      // call/ret ignored without the stack
      run(v(0,0,0,0,32'h0, 0,1,1,1, 32'h8, 1,0,0,1));
      run(v(0,0,0,0,32'h0, 0,0,0,1, 32'h8, 1,0,0,1));
      run(v(0,0,0,0,32'h0, 0,1,1,0, 32'hC, 1,0,0,1));
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
